// File: rtl/mem_access_unit.sv
// Load/store initiator: byte-address requests to word-indexed memory, RMW for sub-word stores.
// Latency: load/word store 2, sub-word store 3, error 1 cycle; one request in flight, req_ready low while busy.
module mem_access_unit #(
  parameter int ADDR_LIMIT = 3100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_mem_Address,
  output logic [31:0] o_mem_WriteData,
  output logic        o_mem_MemWrite,
  output logic        o_mem_MemRead,
  input  logic [31:0] i_mem_ReadData
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [29:0] LIMIT_IDX = 30'(ADDR_LIMIT);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [29:0] r_word_idx;
  logic [1:0]  r_byte_off;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_req_err;
  logic        w_mem_rd;
  logic        w_mem_wr;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic [31:0] w_lane_mask;
  logic [31:0] w_lane_data;
  logic [31:0] w_merged;

  // Rejected requests never leave IDLE through a memory state.
  assign w_req_err = (i_req_size == 2'b11)
                   | ((i_req_size == SZ_HALF) & i_req_addr[0])
                   | ((i_req_size == SZ_WORD) & (i_req_addr[1:0] != 2'b00))
                   | (i_req_addr[31:2] > LIMIT_IDX);

  // Load lane extraction: bring the addressed lane down to bit 0, then extend.
  assign w_shifted = i_mem_ReadData >> {r_byte_off, 3'b000};

  always_comb begin
    w_load = i_mem_ReadData;
    case (r_size)
      SZ_BYTE: w_load = r_unsigned ? {24'h0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load = r_unsigned ? {16'h0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = i_mem_ReadData;
    endcase
  end

  // Store data is right-aligned; replicate it so the mask alone picks the lane.
  always_comb begin
    w_lane_mask = 32'hFFFF_FFFF;
    w_lane_data = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_lane_mask = 32'h0000_00FF << {r_byte_off, 3'b000};
        w_lane_data = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_lane_mask = r_byte_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_lane_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_lane_mask = 32'hFFFF_FFFF;
        w_lane_data = r_wdata;
      end
    endcase
  end

  assign w_merged = (i_mem_ReadData & ~w_lane_mask) | (w_lane_data & w_lane_mask);

  always_comb begin
    w_next_state = r_state;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (w_req_err)                  w_next_state = RESP;
          else if (!i_req_write)          w_next_state = READ;
          else if (i_req_size == SZ_WORD) w_next_state = WRITE;
          else                            w_next_state = RMW_READ;
        end
      end
      READ: begin
        w_mem_rd     = 1'b1;
        w_next_state = RESP;
      end
      RMW_READ: begin
        w_mem_rd     = 1'b1;
        w_next_state = WRITE;
      end
      WRITE: begin
        w_mem_wr     = 1'b1;
        w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_word_idx <= 30'h0;
      r_byte_off <= 2'b00;
      r_wdata    <= 32'h0;
      r_merge    <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_word_idx <= i_req_addr[31:2];
            r_byte_off <= i_req_addr[1:0];
            r_wdata    <= i_req_wdata;
            r_merge    <= i_req_wdata;
            r_rdata    <= 32'h0;
            r_err      <= w_req_err;
          end
        end
        READ:     r_rdata <= w_load;
        RMW_READ: r_merge <= w_merged;
        default:  ;
      endcase
    end
  end

  assign o_req_ready     = (r_state == IDLE);
  assign o_resp_valid    = (r_state == RESP);
  assign o_resp_rdata    = (r_state == RESP) ? r_rdata : 32'h0;
  assign o_resp_err      = (r_state == RESP) ? r_err : 1'b0;
  assign o_mem_MemRead   = w_mem_rd;
  assign o_mem_MemWrite  = w_mem_wr;
  assign o_mem_Address   = (w_mem_rd | w_mem_wr) ? {2'b00, r_word_idx} : 32'h0;
  assign o_mem_WriteData = w_mem_wr ? r_merge : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized requests against a word-array model.
module tb_mem_access_unit;
  localparam int LIMIT = 3100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_LIMIT(LIMIT)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_mem_Address  (mem_addr),
    .o_mem_WriteData(mem_wdata),
    .o_mem_MemWrite (mem_wr),
    .o_mem_MemRead  (mem_rd),
    .i_mem_ReadData (mem_rdata)
  );

  // Memory seen by the DUT, and the reference copy the model reasons about.
  logic [31:0] tb_mem  [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_idx = 12'h0;
  logic [31:0] pre_dat = 32'h0;

  always @(posedge clk) begin
    if (mem_wr)      tb_mem[mem_addr[11:0]] <= mem_wdata;
    else if (pre_we) tb_mem[pre_idx] <= pre_dat;
  end
  assign mem_rdata = mem_rd ? tb_mem[mem_addr[11:0]] : 32'h0;

  int overlap_cnt = 0;
  int idle_strobe_cnt = 0;
  int zero_cnt = 0;
  always @(negedge clk) begin
    if (mem_rd && mem_wr) overlap_cnt++;
    if ((req_ready || resp_valid) && (mem_rd || mem_wr)) idle_strobe_cnt++;
    if (!mem_rd && !mem_wr && (mem_addr != 32'h0 || mem_wdata != 32'h0)) zero_cnt++;
  end

  // Per-request observation, cycle numbers counted from the acceptance edge.
  int          ob_rd_cyc, ob_wr_cyc, ob_resp_cyc, ob_nresp;
  logic [31:0] ob_rd_addr, ob_wr_addr, ob_wr_data, ob_rdata;
  logic        ob_err;

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = 12'(idx);
    pre_dat = val;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    ob_rd_cyc = 0; ob_wr_cyc = 0; ob_resp_cyc = 0; ob_nresp = 0;
    ob_rd_addr = 0; ob_wr_addr = 0; ob_wr_data = 0; ob_rdata = 0; ob_err = 0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) begin
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      if (mem_rd && ob_rd_cyc == 0) begin ob_rd_cyc = j; ob_rd_addr = mem_addr; end
      if (mem_wr && ob_wr_cyc == 0) begin
        ob_wr_cyc = j; ob_wr_addr = mem_addr; ob_wr_data = mem_wdata;
      end
      if (resp_valid) begin
        ob_nresp++;
        if (ob_resp_cyc == 0) begin ob_resp_cyc = j; ob_rdata = resp_rdata; ob_err = resp_err; end
      end
    end
  endtask

  // Reference behaviour from the lane/extension rules, using plain arithmetic on the word.
  task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rdata,
                       output logic [31:0] nw, output int lat);
    logic [31:0] w, lane;
    int unsigned idx, k;
    idx = addr / 4;
    k   = addr % 4;
    err = (sz == 2'd3) || (sz == 2'd1 && k % 2 != 0) || (sz == 2'd2 && k != 0) || (idx > LIMIT);
    rdata = 0; nw = 0; lat = 1;
    if (!err) begin
      w = ref_mem[idx];
      if (!wr) begin
        lat = 2;
        if (sz == 2'd0) begin
          lane  = (w >> (8 * k)) % 256;
          rdata = (!uns && lane >= 128) ? lane - 256 : lane;
        end else if (sz == 2'd1) begin
          lane  = (w >> (8 * k)) % 65536;
          rdata = (!uns && lane >= 32768) ? lane - 65536 : lane;
        end else rdata = w;
      end else if (sz == 2'd2) begin
        lat = 2; nw = wd;
      end else begin
        lat = 3;
        if (sz == 2'd0) begin
          lane = (w >> (8 * k)) % 256;
          nw   = w - (lane << (8 * k)) + ((wd % 256) << (8 * k));
        end else begin
          lane = (w >> (8 * k)) % 65536;
          nw   = w - (lane << (8 * k)) + ((wd % 65536) << (8 * k));
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_err, mem_rd, mem_wr} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: ready/rv/err/rd/wr=%b required 10000",
               {req_ready, resp_valid, resp_err, mem_rd, mem_wr});
    end
    n_vec++;
    if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h required 0", resp_rdata); end
    n_vec++;
    if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
    n_vec++;
    if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h required 0", mem_wdata); end
    req_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    ref_mem[4] = 32'hDEADBEEF;
    n_vec++;
    if ({ob_rd_cyc, ob_wr_cyc, ob_resp_cyc} !== {32'd0, 32'd1, 32'd2}) begin
      n_err++; $display("FAIL wst_timing: rd/wr/resp=%0d/%0d/%0d required 0/1/2", ob_rd_cyc, ob_wr_cyc, ob_resp_cyc);
    end
    n_vec++;
    if ({ob_wr_addr, ob_wr_data} !== {32'd4, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL wst_write: addr=%h data=%h required 4 deadbeef", ob_wr_addr, ob_wr_data);
    end
    n_vec++;
    if ({ob_err, ob_rdata} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL wst_resp: err=%b rdata=%h required 0 0", ob_err, ob_rdata);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    n_vec++;
    if ({ob_rd_cyc, ob_wr_cyc, ob_resp_cyc} !== {32'd1, 32'd0, 32'd2}) begin
      n_err++; $display("FAIL wld_timing: rd/wr/resp=%0d/%0d/%0d required 1/0/2", ob_rd_cyc, ob_wr_cyc, ob_resp_cyc);
    end
    n_vec++;
    if ({ob_rd_addr, ob_err, ob_rdata} !== {32'd4, 1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL wld_data: addr=%h err=%b rdata=%h required 4 0 deadbeef", ob_rd_addr, ob_err, ob_rdata);
    end
  endtask

  task automatic test_byte_store();
    preload(4, 32'h11223344);
    run_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h555555AB);
    ref_mem[4] = 32'h11AB3344;
    n_vec++;
    if ({ob_rd_cyc, ob_wr_cyc, ob_resp_cyc, ob_nresp} !== {32'd1, 32'd2, 32'd3, 32'd1}) begin
      n_err++; $display("FAIL bst_timing: rd/wr/resp/n=%0d/%0d/%0d/%0d required 1/2/3/1",
                        ob_rd_cyc, ob_wr_cyc, ob_resp_cyc, ob_nresp);
    end
    n_vec++;
    if ({ob_wr_addr, ob_wr_data} !== {32'd4, 32'h11AB3344}) begin
      n_err++; $display("FAIL bst_merge: addr=%h data=%h required 4 11ab3344", ob_wr_addr, ob_wr_data);
    end
  endtask

  task automatic test_extension();
    logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        uns [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [4] = '{32'h10, 32'h11, 32'h12, 32'h12};
    logic [31:0] ex  [4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00008000, 32'hFFFF8000};
    preload(4, 32'h8000FF7F);
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, sz[i], uns[i], ad[i], 32'h0);
      n_vec++;
      if ({ob_resp_cyc, ob_err, ob_rdata} !== {32'd2, 1'b0, ex[i]}) begin
        n_err++; $display("FAIL ext[%0d]: cyc=%0d err=%b rdata=%h required 2 0 %h",
                          i, ob_resp_cyc, ob_err, ob_rdata, ex[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        wr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic [31:0] ad [4] = '{32'h13, 32'h11, 32'h10, 32'd12404};
    for (int i = 0; i < 4; i++) begin
      run_req(wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF);
      n_vec++;
      if ({ob_resp_cyc, ob_nresp, ob_err, ob_rdata} !== {32'd1, 32'd1, 1'b1, 32'h0}) begin
        n_err++; $display("FAIL err_resp[%0d]: cyc=%0d n=%0d err=%b rdata=%h required 1 1 1 0",
                          i, ob_resp_cyc, ob_nresp, ob_err, ob_rdata);
      end
      n_vec++;
      if ({ob_rd_cyc, ob_wr_cyc} !== {32'd0, 32'd0}) begin
        n_err++; $display("FAIL err_strobe[%0d]: rd=%0d wr=%0d required 0 0", i, ob_rd_cyc, ob_wr_cyc);
      end
    end
  endtask

  task automatic test_reset_rmw();
    int writes = 0, resps = 0;
    preload(5, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h15; req_wdata = 32'h99;
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if (mem_rd !== 1'b1) begin n_err++; $display("FAIL rmw_read: MemRead=%b required 1", mem_rd); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (mem_wr) writes++;
      if (resp_valid) resps++;
      if (j == 1) begin
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b required 1", req_ready); end
      end
      @(negedge clk);
    end
    n_vec++;
    if ({writes, resps} !== {32'd0, 32'd0}) begin
      n_err++; $display("FAIL rst_abandon: writes=%0d resps=%0d required 0 0", writes, resps);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    n_vec++;
    if (ob_rdata !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL rst_memory: got %h required cafef00d", ob_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int nresp = 0;
    logic [31:0] val;
    val = $urandom;
    preload(7, val);
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_addr = 32'h1C; req_unsigned = 1'b0;
    for (int t = 0; t < 15; t++) begin
      req_valid = (t < 10);
      if (req_valid && req_ready) acc.push_back(t);
      if (resp_valid) begin
        nresp++;
        n_vec++;
        if (resp_rdata !== val) begin n_err++; $display("FAIL b2b_rdata: got %h required %h", resp_rdata, val); end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_vec++;
    if (acc.size() !== 4 || nresp !== 4) begin
      n_err++; $display("FAIL b2b_count: accepts=%0d resps=%0d required 4 4", acc.size(), nresp);
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_vec++;
      if (acc[i] - acc[i-1] !== 3) begin
        n_err++; $display("FAIL b2b_gap[%0d]: got %0d required 3", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    preload(LIMIT, $urandom);
    for (int i = 0; i < 60; i++) begin
      logic wr, uns, e;
      logic [1:0] sz;
      logic [31:0] addr, wd, exp_rd_data, nw;
      int unsigned idx, off, pick;
      int lat, exp_rd, exp_wr;
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      pick = $urandom_range(0, 9);
      idx  = (pick == 0) ? LIMIT : (pick == 1) ? LIMIT + 1 + $urandom_range(0, 99) : $urandom_range(0, 15);
      off  = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) off = (sz == 2'd2) ? 0 : (sz == 2'd1) ? (off & 2) : off;
      addr = idx * 4 + off;
      wd   = $urandom;
      model(wr, sz, uns, addr, wd, e, exp_rd_data, nw, lat);
      run_req(wr, sz, uns, addr, wd);
      exp_rd = (!e && (!wr || sz != 2'd2)) ? 1 : 0;
      exp_wr = (e || !wr) ? 0 : (sz == 2'd2) ? 1 : 2;
      n_vec++;
      if (ob_resp_cyc !== lat || ob_nresp !== 1) begin
        n_err++; $display("FAIL rnd_resp_cyc[%0d]: cyc=%0d n=%0d required %0d 1", i, ob_resp_cyc, ob_nresp, lat);
      end
      n_vec++;
      if ({ob_err, ob_rdata} !== {e, exp_rd_data}) begin
        n_err++; $display("FAIL rnd_rdata[%0d]: err=%b rdata=%h required %b %h", i, ob_err, ob_rdata, e, exp_rd_data);
      end
      n_vec++;
      if (ob_rd_cyc !== exp_rd || ob_wr_cyc !== exp_wr) begin
        n_err++; $display("FAIL rnd_strobes[%0d]: rd=%0d wr=%0d required %0d %0d", i, ob_rd_cyc, ob_wr_cyc, exp_rd, exp_wr);
      end
      if (exp_rd != 0) begin
        n_vec++;
        if (ob_rd_addr !== idx) begin
          n_err++; $display("FAIL rnd_rd_addr[%0d]: got %h required %h", i, ob_rd_addr, idx);
        end
      end
      if (exp_wr != 0) begin
        n_vec++;
        if ({ob_wr_addr, ob_wr_data} !== {idx, nw}) begin
          n_err++; $display("FAIL rnd_write[%0d]: addr=%h data=%h required %h %h", i, ob_wr_addr, ob_wr_data, idx, nw);
        end
        ref_mem[idx] = nw;
      end
    end
  endtask

  task automatic test_invariants();
    n_vec++;
    if ({overlap_cnt, idle_strobe_cnt, zero_cnt} !== {32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL invariants: overlap=%0d idle_strobe=%0d nonzero_idle_bus=%0d required 0 0 0",
                        overlap_cnt, idle_strobe_cnt, zero_cnt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_extension();
    test_errors();
    test_reset_rmw();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
